// File: rtl/mask_pkg.sv
// Shared types and PRNG step for the Boolean share encoder.
// xorshift32 is the single source of mask and refresh randomness.
package mask_pkg;

  localparam int PRNG_W = 32;
  localparam logic [PRNG_W-1:0] ZERO_SEED_SUB = 32'h00000001;

  typedef enum logic {
    UNSEEDED = 1'b0,
    RUN      = 1'b1
  } enc_state_t;

  function automatic logic [PRNG_W-1:0] xorshift32_next(input logic [PRNG_W-1:0] x);
    logic [PRNG_W-1:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

endpackage

// File: rtl/mask_share_encoder_if.sv
// Producer/consumer bundle of the share encoder: seed load, input word,
// output shares, refresh bus and reseed request.
interface mask_share_encoder_if #(
  parameter int NUM_SHARES = 2,
  parameter int WIDTH      = 8,
  parameter int REFRESH_W  = 3
);
  import mask_pkg::*;

  logic                        seed_valid;
  logic [PRNG_W-1:0]           seed;
  logic                        in_valid;
  logic                        in_ready;
  logic [WIDTH-1:0]            in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [NUM_SHARES*WIDTH-1:0] out_shares;
  logic [REFRESH_W-1:0]        refresh;
  logic                        refresh_valid;
  logic                        reseed_req;

  modport master (
    output seed_valid, seed, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_shares, refresh, refresh_valid, reseed_req
  );

  modport slave (
    input  seed_valid, seed, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_shares, refresh, refresh_valid, reseed_req
  );

endinterface

// File: rtl/mask_prng_xorshift32.sv
// Seedable xorshift32 state register; load wins over advance, zero seed is
// replaced so the generator can never lock up at the all-zero fixed point.
module mask_prng_xorshift32
  import mask_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic [PRNG_W-1:0] seed,
  input  logic              advance,
  output logic [PRNG_W-1:0] state
);

  logic [PRNG_W-1:0] r_state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= '0;
    end else if (load) begin
      r_state <= (seed == '0) ? ZERO_SEED_SUB : seed;
    end else if (advance) begin
      r_state <= xorshift32_next(r_state);
    end
  end

  assign state = r_state;

endmodule

// File: rtl/mask_share_encoder.sv
// Splits each word into NUM_SHARES Boolean shares; latency 1, one output register,
// 1 word/cycle; in_ready drops while the held output is not taken.
module mask_share_encoder
  import mask_pkg::*;
#(
  parameter int NUM_SHARES      = 2,
  parameter int WIDTH           = 8,
  parameter int REFRESH_W       = 3,
  parameter int RESEED_INTERVAL = 1024
) (
  input logic                 clock,
  input logic                 reset_n,
  mask_share_encoder_if.slave bus
);

  localparam int CNT_W = $clog2(RESEED_INTERVAL + 1);

  if ((NUM_SHARES < 2) || (NUM_SHARES > 4)) begin : g_bad_shares
    $error("mask_share_encoder: NUM_SHARES must be in 2..4");
  end
  if ((NUM_SHARES - 1) * WIDTH + REFRESH_W > PRNG_W) begin : g_bad_width
    $error("mask_share_encoder: mask and refresh bits exceed the PRNG word");
  end

  enc_state_t                  r_fsm;
  logic                        r_out_vld;
  logic [NUM_SHARES*WIDTH-1:0] r_out_shares;
  logic [REFRESH_W-1:0]        r_refresh;
  logic                        r_refresh_vld;
  logic [CNT_W-1:0]            r_count;

  logic [PRNG_W-1:0]           w_state;
  logic                        w_advance;
  logic                        w_in_rdy;
  logic                        w_accept;
  logic                        w_reseed;
  logic [NUM_SHARES*WIDTH-1:0] w_shares;
  logic [WIDTH-1:0]            w_acc;
  logic                        w_unused_state;

  assign w_advance = (r_fsm == RUN) && !bus.seed_valid;
  assign w_in_rdy  = (r_fsm == RUN) && (!r_out_vld || bus.out_ready);
  assign w_accept  = bus.in_valid && w_in_rdy;
  assign w_reseed  = (r_count == CNT_W'(RESEED_INTERVAL));

  // Bits between the masks and the refresh field are deliberately discarded.
  assign w_unused_state = ^w_state;

  mask_prng_xorshift32 u_prng (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (bus.seed_valid),
    .seed    (bus.seed),
    .advance (w_advance),
    .state   (w_state)
  );

  always_comb begin
    w_shares = '0;
    w_acc    = '0;
    for (int j = 0; j < NUM_SHARES - 1; j++) begin
      w_shares[j*WIDTH +: WIDTH] = w_state[j*WIDTH +: WIDTH];
      w_acc                      = w_acc ^ w_state[j*WIDTH +: WIDTH];
    end
    w_shares[(NUM_SHARES-1)*WIDTH +: WIDTH] = bus.in_data ^ w_acc;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fsm         <= UNSEEDED;
      r_out_vld     <= 1'b0;
      r_out_shares  <= '0;
      r_refresh     <= '0;
      r_refresh_vld <= 1'b0;
      r_count       <= '0;
    end else begin
      case (r_fsm)
        UNSEEDED: if (bus.seed_valid) r_fsm <= RUN;
        RUN:      r_fsm <= RUN;
        default:  r_fsm <= UNSEEDED;
      endcase

      if (w_accept) begin
        r_out_vld    <= 1'b1;
        r_out_shares <= w_shares;
      end else if (bus.out_ready) begin
        r_out_vld    <= 1'b0;
      end

      // Refresh comes from the top of S, disjoint from the mask slices.
      if (r_fsm == RUN) begin
        r_refresh     <= w_state[PRNG_W-1 -: REFRESH_W];
        r_refresh_vld <= 1'b1;
      end

      if (bus.seed_valid) begin
        r_count <= '0;
      end else if (w_accept && !w_reseed) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready      = w_in_rdy;
  assign bus.out_valid     = r_out_vld;
  assign bus.out_shares    = r_out_shares;
  assign bus.refresh       = r_refresh;
  assign bus.refresh_valid = r_refresh_vld;
  assign bus.reseed_req    = w_reseed;

endmodule

// File: tb/tb_mask_share_encoder.sv
// Scoreboarded bench for mask_share_encoder: a behavioural model tracks
// handshake, PRNG and refresh each cycle; expected shares queue on accept.
module tb_mask_share_encoder;

  localparam int NS = 2;
  localparam int W  = 8;
  localparam int RW = 3;

  typedef struct packed {
    logic [NS*W-1:0] sh;
    logic [W-1:0]    d;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   errs = 0;
  int   checks = 0;
  exp_t exp_q[$];

  logic          m_run, m_out_vld, m_ref_vld, m_in_rdy, m_acc;
  logic [31:0]   m_s;
  logic [RW-1:0] m_refresh;
  exp_t          m_e;
  exp_t          m_pop;

  always #5 clock = ~clock;

  mask_share_encoder_if #(.NUM_SHARES(NS), .WIDTH(W), .REFRESH_W(RW)) bus ();

  mask_share_encoder #(
    .NUM_SHARES(NS), .WIDTH(W), .REFRESH_W(RW), .RESEED_INTERVAL(4)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic logic [31:0] xs32(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ {x[18:0], 13'b0};
    t = t ^ {17'b0, t[31:17]};
    t = t ^ {t[26:0], 5'b0};
    return t;
  endfunction

  function automatic logic [W-1:0] fold(input logic [NS*W-1:0] s);
    logic [W-1:0] r;
    r = '0;
    for (int j = 0; j < NS; j++) r = r ^ s[j*W +: W];
    return r;
  endfunction

  // Reference model plus scoreboard: compares the current cycle, then steps
  // the model across the coming rising edge using the inputs now applied.
  always @(negedge clock) begin
    if (!reset_n) begin
      m_run = 1'b0; m_out_vld = 1'b0; m_ref_vld = 1'b0;
      m_s = '0; m_refresh = '0;
      exp_q.delete();
    end else begin
      m_in_rdy = m_run && (!m_out_vld || bus.out_ready);
      checks++;
      if (bus.in_ready !== m_in_rdy)
        $display("FAIL model_in_ready: got %b expected %b", bus.in_ready, m_in_rdy);
      checks++;
      if (bus.out_valid !== m_out_vld)
        $display("FAIL model_out_valid: got %b expected %b", bus.out_valid, m_out_vld);
      checks++;
      if ({bus.refresh_valid, bus.refresh} !== {m_ref_vld, m_refresh})
        $display("FAIL model_refresh: got %b/%h expected %b/%h",
                 bus.refresh_valid, bus.refresh, m_ref_vld, m_refresh);
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL sb_underflow: got transfer %h expected none", bus.out_shares);
        end else begin
          m_pop = exp_q.pop_front();
          if (bus.out_shares !== m_pop.sh) begin
            errs++;
            $display("FAIL sb_shares: got %h expected %h", bus.out_shares, m_pop.sh);
          end
          checks++;
          if (fold(bus.out_shares) !== m_pop.d) begin
            errs++;
            $display("FAIL sb_xor: got %h expected %h", fold(bus.out_shares), m_pop.d);
          end
        end
      end
      if (bus.in_ready !== m_in_rdy || bus.out_valid !== m_out_vld ||
          {bus.refresh_valid, bus.refresh} !== {m_ref_vld, m_refresh})
        errs = errs + ((bus.in_ready !== m_in_rdy) ? 1 : 0)
                    + ((bus.out_valid !== m_out_vld) ? 1 : 0)
                    + (({bus.refresh_valid, bus.refresh} !== {m_ref_vld, m_refresh}) ? 1 : 0);

      m_acc = bus.in_valid && m_in_rdy;
      if (m_acc) begin
        m_e.d  = bus.in_data;
        m_e.sh = '0;
        for (int j = 0; j < NS - 1; j++) m_e.sh[j*W +: W] = m_s[j*W +: W];
        m_e.sh[(NS-1)*W +: W] = bus.in_data ^ fold(m_e.sh);
        exp_q.push_back(m_e);
      end
      m_out_vld = m_acc ? 1'b1 : (bus.out_ready ? 1'b0 : m_out_vld);
      if (m_run) begin
        m_refresh = m_s[31 -: RW];
        m_ref_vld = 1'b1;
      end
      if (bus.seed_valid)
        m_s = (bus.seed == 32'h0) ? 32'h1 : bus.seed;
      else if (m_run)
        m_s = xs32(m_s);
      m_run = m_run || bus.seed_valid;
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    bus.seed_valid = 1'b0; bus.seed = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic load_seed(input logic [31:0] s);
    bus.seed_valid = 1'b1; bus.seed = s;
    @(posedge clock); #1;
    bus.seed_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_shares !== '0) begin errs++; $display("FAIL reset_out_shares: got %h expected 0", bus.out_shares); end
    checks++; if (bus.refresh !== '0) begin errs++; $display("FAIL reset_refresh: got %h expected 0", bus.refresh); end
    checks++; if (bus.refresh_valid !== 1'b0) begin errs++; $display("FAIL reset_refresh_valid: got %b expected 0", bus.refresh_valid); end
    checks++; if (bus.reseed_req !== 1'b0) begin errs++; $display("FAIL reset_reseed_req: got %b expected 0", bus.reseed_req); end
    checks++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
  endtask

  task automatic test_unseeded();
    do_reset();
    bus.in_valid = 1'b1; bus.in_data = 8'h5A; bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.refresh_valid} !== 3'b000) begin
        errs++;
        $display("FAIL unseeded_cycle%0d: got rdy/vld/rvld=%b expected 000", i,
                 {bus.in_ready, bus.out_valid, bus.refresh_valid});
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_back_to_back(input logic [31:0] s, input string tag);
    do_reset();
    load_seed(s);
    bus.in_valid = 1'b1; bus.in_data = 8'hA5; bus.out_ready = 1'b1;
    checks++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL %s_in_ready: got %b expected 1", tag, bus.in_ready); end
    @(posedge clock); #1;
    bus.in_data = 8'h3C;
    checks++; if (bus.out_shares !== 16'hA401) begin errs++; $display("FAIL %s_word0: got %h expected a401", tag, bus.out_shares); end
    checks++; if (bus.refresh_valid !== 1'b1) begin errs++; $display("FAIL %s_refresh_valid: got %b expected 1", tag, bus.refresh_valid); end
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_shares !== 16'h1D21) begin errs++; $display("FAIL %s_word1: got %h expected 1d21", tag, bus.out_shares); end
    @(posedge clock); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL %s_vld_fall: got %b expected 0", tag, bus.out_valid); end
    checks++; if (exp_q.size() != 0) begin errs++; $display("FAIL %s_drain: got %0d pending expected 0", tag, exp_q.size()); end
  endtask

  task automatic test_backpressure();
    do_reset();
    load_seed(32'h9E3779B9);
    bus.in_valid = 1'b1; bus.in_data = 8'h11; bus.out_ready = 1'b0;
    @(posedge clock); #1;
    bus.in_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || exp_q.size() != 1 ||
          bus.out_shares !== exp_q[0].sh) begin
        errs++;
        $display("FAIL bp_hold%0d: got vld=%b rdy=%b sh=%h expected vld=1 rdy=0 held word", i,
                 bus.out_valid, bus.in_ready, bus.out_shares);
      end
      @(posedge clock); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL bp_release_rdy: got %b expected 1", bus.in_ready); end
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    checks++; if (fold(bus.out_shares) !== 8'h22) begin errs++; $display("FAIL bp_next_word: got %h expected 22", fold(bus.out_shares)); end
    @(posedge clock); #1;
    checks++; if (exp_q.size() != 0) begin errs++; $display("FAIL bp_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_reseed_counter();
    do_reset();
    load_seed(32'h12345678);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = W'(i * 17 + 3);
      @(posedge clock); #1;
      checks++;
      if (bus.reseed_req !== (i == 3)) begin
        errs++; $display("FAIL reseed_count%0d: got %b expected %b", i, bus.reseed_req, (i == 3));
      end
    end
    bus.in_data = 8'h5E; bus.seed_valid = 1'b1; bus.seed = 32'hCAFEF00D;
    @(posedge clock); #1;
    bus.seed_valid = 1'b0;
    checks++; if (bus.reseed_req !== 1'b0) begin errs++; $display("FAIL reseed_clear: got %b expected 0", bus.reseed_req); end
    for (int i = 0; i < 4; i++) begin
      bus.in_data = W'(8'hC0 + i);
      @(posedge clock); #1;
      checks++;
      if (bus.reseed_req !== (i == 3)) begin
        errs++; $display("FAIL reseed_recount%0d: got %b expected %b", i, bus.reseed_req, (i == 3));
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clock); #1;
    checks++; if (exp_q.size() != 0) begin errs++; $display("FAIL reseed_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_async_reset();
    do_reset();
    load_seed(32'hFFFFFFFF);
    bus.in_valid = 1'b1; bus.in_data = 8'h77; bus.out_ready = 1'b0;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errs++; $display("FAIL arst_pending: got %b expected 1", bus.out_valid); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_shares, bus.refresh, bus.refresh_valid, bus.in_ready} !== '0) begin
      errs++;
      $display("FAIL arst_immediate: got vld=%b sh=%h ref=%h rvld=%b rdy=%b expected all 0",
               bus.out_valid, bus.out_shares, bus.refresh, bus.refresh_valid, bus.in_ready);
    end
    @(posedge clock); #1;
    reset_n = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clock); #1;
    checks++; if ({bus.in_ready, bus.out_valid} !== 2'b00) begin errs++; $display("FAIL arst_unseeded: got rdy/vld=%b expected 00", {bus.in_ready, bus.out_valid}); end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unseeded();
    test_back_to_back(32'h00000001, "seed1");
    test_back_to_back(32'h00000000, "seed0");
    test_backpressure();
    test_reseed_counter();
    test_async_reset();
    repeat (2) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got no completion expected finish before 50000");
    $fatal(1, "watchdog expired");
  end

endmodule
